// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier FSM state encoding, default datapath width, width helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    // Default ALU datapath width.
    localparam int ALU_W = 32;

    // Sequential multiplier control states.
    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

    // ceil(log2(v)), clamped to at least 1 so a counter always has one bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < v) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/add_all.sv
// N-bit ripple-carry adder used by the ALU and by the sequential multiplier.
// Latency: combinational. Backpressure: none.
// Ports: a_i/b_i operands, cin_i carry-in, sum_o N-bit sum, cout_o carry-out.
module add_all #(
    parameter int N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    logic c;

    always_comb begin
        sum_o = '0;
        c     = cin_i;
        for (int i = 0; i < N; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c;
            c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
        end
        cout_o = c;
    end

endmodule

// File: rtl/mul_seq.sv
// Iterative shift-and-add unsigned multiplier built around one add_all instance.
// Latency: N+1 cycles start->done (1 cycle for zero operands when MUL_SEQ_ZERO_BYPASS_EN is defined).
// Backpressure: none; start is only accepted in IDLE or DONE, ignored while busy.
// Ports: clk, rst (async active-high), start/a/b request, busy, done pulse, product (held).
// Optional feature macro: MUL_SEQ_ZERO_BYPASS_EN (zero operand skips the iteration).
module mul_seq
    import alu_pkg::*;
#(
    parameter int N = ALU_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int            CW       = clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    mul_state_t      state_q, state_d;
    logic [2*N-1:0]  acc_q, acc_d;
    logic [N-1:0]    mcand_q, mcand_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*N-1:0]  product_q, product_d;

    logic [N-1:0]    add_b;
    logic [N-1:0]    sum;
    logic            cout;
    logic [2*N-1:0]  acc_shift;
    logic            zero_op;

    // Upper half of acc accumulates; low half holds the not-yet-consumed
    // multiplier bits, LSB first.
    assign add_b = acc_q[0] ? mcand_q : '0;

    add_all #(.N(N)) u_add (
        .a_i    (acc_q[2*N-1:N]),
        .b_i    (add_b),
        .cin_i  (1'b0),
        .sum_o  (sum),
        .cout_o (cout)
    );

    // Carry-out becomes the new MSB, so no partial sum is ever lost.
    assign acc_shift = {cout, sum, acc_q[N-1:1]};

`ifdef MUL_SEQ_ZERO_BYPASS_EN
    assign zero_op = (a == '0) || (b == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            MUL_IDLE, MUL_DONE: begin
                if (start) begin
                    mcand_d = a;
                    acc_d   = {{N{1'b0}}, b};
                    cnt_d   = '0;
                    if (zero_op) begin
                        product_d = '0;
                        state_d   = MUL_DONE;
                    end else begin
                        state_d   = MUL_RUN;
                    end
                end else begin
                    state_d = MUL_IDLE;
                end
            end
            MUL_RUN: begin
                acc_d = acc_shift;
                if (cnt_q == CNT_LAST) begin
                    // Final iteration: capture the result straight from the
                    // shifted value so it is visible during the DONE cycle.
                    // cnt is left at N-1 rather than wrapping.
                    product_d = acc_shift;
                    state_d   = MUL_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= MUL_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == MUL_RUN);
    assign done    = (state_q == MUL_DONE);
    assign product = product_q;

endmodule

// File: tb/tb_mul_seq.sv
module tb_mul_seq;

    localparam int N = 32;

    logic           clk;
    logic           rst;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    int checks   = 0;
    int failures = 0;

    mul_seq #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a start pulse; returns positioned in cycle k+1.
    task automatic issue(input logic [N-1:0] av, input logic [N-1:0] bv);
        a     = av;
        b     = bv;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Cycles k+1..k+N must show busy only; returns positioned in cycle k+N+1.
    task automatic run_phase(input string tag);
        int bad_busy;
        int bad_done;
        bad_busy = 0;
        bad_done = 0;
        for (int i = 1; i <= N; i++) begin
            if (busy !== 1'b1) bad_busy++;
            if (done !== 1'b0) bad_done++;
            step();
        end
        chk({tag, "_busy_cycles_bad"}, 64'(bad_busy), 64'd0);
        chk({tag, "_early_done_cycles"}, 64'(bad_done), 64'd0);
    endtask

    task automatic done_phase(input string tag, input logic [63:0] exp);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_busy_in_done"}, 64'(busy), 64'd0);
        chk({tag, "_product"}, product, exp);
    endtask

    initial begin
        int bad;
        int saw_done;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_product", product, 64'd0);

        // Idle after reset with no start.
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) bad++;
        end
        chk("idle_bad_cycles", 64'(bad), 64'd0);

        // 7 * 6 = 42
        issue(32'd7, 32'd6);
        run_phase("m7x6");
        done_phase("m7x6", 64'd42);
        step();
        chk("m7x6_done_pulse_end", 64'(done), 64'd0);
        chk("m7x6_product_held", product, 64'd42);
        step();

        // Max operands: carry retained every iteration.
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_phase("mmax");
        done_phase("mmax", 64'hFFFF_FFFE_0000_0001);
        step();

        // Back-to-back with a start ignored mid-RUN.
        a     = 32'd3;
        b     = 32'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        bad   = 0;
        for (int i = 1; i <= N; i++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            if (i == 5) begin
                a     = 32'd9;
                b     = 32'd9;
                start = 1'b1;
            end
            step();
            start = 1'b0;
        end
        chk("b2b_first_run_bad", 64'(bad), 64'd0);
        done_phase("b2b_first", 64'd15);
        // start during the DONE cycle is accepted
        issue(32'd12, 32'd11);
        run_phase("b2b_second");
        done_phase("b2b_second", 64'd132);
        step();

        // Reset mid-operation at cycle k+10.
        issue(32'd100, 32'd100);
        repeat (9) step();
        chk("abort_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_product", product, 64'd0);
        step();
        rst      = 1'b0;
        saw_done = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done !== 1'b0 || busy !== 1'b0) saw_done++;
        end
        chk("abort_no_activity", 64'(saw_done), 64'd0);
        issue(32'd2, 32'd2);
        run_phase("m2x2");
        done_phase("m2x2", 64'd4);
        step();

        // Zero operand.
        issue(32'd0, 32'd1234);
`ifdef MUL_SEQ_ZERO_BYPASS_EN
        done_phase("zero_bypass", 64'd0);
        step();
        chk("zero_bypass_busy_after", 64'(busy), 64'd0);
        chk("zero_bypass_done_after", 64'(done), 64'd0);
`else
        run_phase("zero_full");
        done_phase("zero_full", 64'd0);
        step();
        chk("zero_full_done_after", 64'(done), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
